// File: rtl/alu_seq_pkg.sv
// alu_sequencer shared types: opcodes, FSM states, flag bit indices.
// Used by alu_sequencer and alu_seq_flags.
package alu_seq_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_NOT  = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_PASA = 5'd10;
  localparam logic [4:0] OP_PASB = 5'd11;
  localparam logic [4:0] OP_INC  = 5'd12;
  localparam logic [4:0] OP_DEC  = 5'd13;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    FIX,
    RSP
  } state_t;

  localparam int FLAG_C  = 0;
  localparam int FLAG_N  = 1;
  localparam int FLAG_PV = 2;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_S  = 7;

  typedef struct packed {
    logic [4:0]  op;
    logic        wide;
    logic [15:0] a;
    logic [15:0] b;
  } alu_seq_t;

  function automatic logic is_arith(
    input logic [4:0] op
  );
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic is_wide_op(
    input logic [4:0] op
  );
    return op <= OP_XOR;
  endfunction

endpackage

// File: rtl/alu_seq_flags.sv
// Combinational flag composition for alu_sequencer.
// S/Z flags only exist with ALU_SEQ_SZ_FLAGS_EN defined.
module alu_seq_flags
  import alu_seq_pkg::*;
(
  input  logic [4:0]  op,
  input  logic        wide,
  input  logic        a_msb,
  input  logic        b_msb,
  input  logic        c_hi,
  input  logic        c_fix,
  input  logic [15:0] result,
  input  logic [2:0]  lo_flags,
  output logic [7:0]  flags
);

  logic r_msb;
  logic ovf_add;
  logic ovf_sub;

  assign r_msb   = result[15];
  assign ovf_add = (a_msb == b_msb) && (r_msb != a_msb);
  assign ovf_sub = (a_msb != b_msb) && (r_msb != a_msb);

  always_comb begin
    flags = '0;
    if (wide) begin
      if (is_arith(op)) begin
        flags[FLAG_C]  = c_hi | c_fix;
        flags[FLAG_N]  = (op == OP_SUB);
        flags[FLAG_PV] = (op == OP_SUB) ?
                         ovf_sub : ovf_add;
      end
    end else begin
      flags[2:0] = lo_flags;
    end
`ifdef ALU_SEQ_SZ_FLAGS_EN
    flags[FLAG_S] = wide ? result[15]
                         : result[7];
    flags[FLAG_Z] = wide ? (result == 16'h0)
                         : (result[7:0] == 8'h0);
`endif
  end

`ifndef ALU_SEQ_SZ_FLAGS_EN
  logic unused_res;
  assign unused_res = ^result[14:0];
`endif

endmodule

// File: rtl/alu_sequencer.sv
// 16-bit op sequencer in front of the 8-bit alu (carry chained via INC/DEC).
// Optional S/Z flags: define ALU_SEQ_SZ_FLAGS_EN.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic        req_wide,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [4:0]  alu_opcode,
  input  logic [7:0]  alu_out,
  input  logic [7:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [7:0]  rsp_flags
);

  state_t     state;
  alu_seq_t   req_q;
  logic [7:0] res_lo;
  logic [7:0] res_hi;
  logic       c_lo;
  logic       c_hi;
  logic       c_fix;
  logic [2:0] lo_flags;
  logic [7:0] flags_w;
  logic       need_fix;

  assign req_ready  = (state == IDLE) && !reset;
  assign need_fix   = is_arith(req_q.op) && c_lo;
  assign rsp_result = {res_hi, res_lo};
  assign rsp_flags  = rsp_valid ? flags_w : 8'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_q     <= '0;
      res_lo    <= '0;
      res_hi    <= '0;
      c_lo      <= 1'b0;
      c_hi      <= 1'b0;
      c_fix     <= 1'b0;
      lo_flags  <= '0;
      rsp_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_q <= '{
              op:   req_op,
              wide: req_wide && is_wide_op(req_op),
              a:    req_a,
              b:    req_b
            };
            res_lo   <= '0;
            res_hi   <= '0;
            c_lo     <= 1'b0;
            c_hi     <= 1'b0;
            c_fix    <= 1'b0;
            lo_flags <= '0;
            state    <= LO;
          end
        end
        LO: begin
          res_lo   <= alu_out;
          c_lo     <= alu_flags[FLAG_C];
          lo_flags <= alu_flags[2:0];
          if (req_q.wide) begin
            state <= HI;
          end else begin
            state     <= RSP;
            rsp_valid <= 1'b1;
          end
        end
        HI: begin
          res_hi <= alu_out;
          c_hi   <= alu_flags[FLAG_C];
          if (need_fix) begin
            state <= FIX;
          end else begin
            state     <= RSP;
            rsp_valid <= 1'b1;
          end
        end
        FIX: begin
          res_hi    <= alu_out;
          c_fix     <= alu_flags[FLAG_C];
          state     <= RSP;
          rsp_valid <= 1'b1;
        end
        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = OP_ADD;
    unique case (state)
      LO: begin
        alu_a      = req_q.a[7:0];
        alu_b      = req_q.b[7:0];
        alu_opcode = req_q.op;
      end
      HI: begin
        alu_a      = req_q.a[15:8];
        alu_b      = req_q.b[15:8];
        alu_opcode = req_q.op;
      end
      FIX: begin
        alu_a      = res_hi;
        alu_opcode = (req_q.op == OP_SUB) ?
                     OP_DEC : OP_INC;
      end
      default: begin
      end
    endcase
  end

  alu_seq_flags u_flags (
    .op       (req_q.op),
    .wide     (req_q.wide),
    .a_msb    (req_q.a[15]),
    .b_msb    (req_q.b[15]),
    .c_hi     (c_hi),
    .c_fix    (c_fix),
    .result   (rsp_result),
    .lo_flags (lo_flags),
    .flags    (flags_w)
  );

  logic unused_alu_flags;
  assign unused_alu_flags = ^alu_flags[7:3];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural 8-bit alu plus a 16-bit
// reference model; directed vectors with literal pins.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic        req_wide;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [4:0]  alu_opcode;
  logic [7:0]  alu_out;
  logic [7:0]  alu_flags;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [7:0]  rsp_flags;

  int vecs = 0;
  int errs = 0;

  logic        exp_active = 1'b0;
  logic [15:0] exp_res;
  logic [7:0]  exp_flags;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_wide   (req_wide),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags)
  );

  // 8-bit alu: returns {flags, out}; flags bit0 C, bit1 N, bit2 P/V
  function automatic logic [15:0] alu_f(
    input logic [4:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0] s;
    logic [7:0] o;
    logic [7:0] f;
    f = 8'h0;
    o = a;
    case (op)
      5'd0: begin
        s = {1'b0, a} + {1'b0, b};
        o = s[7:0];
        f[0] = s[8];
        f[2] = (a[7] == b[7]) && (o[7] != a[7]);
      end
      5'd1: begin
        o = a - b;
        f[0] = a < b;
        f[1] = 1'b1;
        f[2] = (a[7] != b[7]) && (o[7] != a[7]);
      end
      5'd2, 5'd3, 5'd4: begin
        o = (op == 5'd2) ? (a & b) :
            (op == 5'd3) ? (a | b) : (a ^ b);
        f[2] = ~^o;
      end
      5'd5: o = ~a;
      5'd12: begin
        o = a + 8'd1;
        f[0] = (a == 8'hFF);
        f[2] = (a == 8'h7F);
      end
      5'd13: begin
        o = a - 8'd1;
        f[0] = (a == 8'h00);
        f[1] = 1'b1;
        f[2] = (a == 8'h80);
      end
      default: o = a;
    endcase
    return {f, o};
  endfunction

  always_comb begin
    {alu_flags, alu_out} = alu_f(alu_opcode, alu_a, alu_b);
  end

  // 16-bit reference: plain arithmetic, no pass sequencing
  function automatic void model(
    input  logic [4:0]  op,
    input  logic        wide,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] r,
    output logic [7:0]  f,
    output int          lat,
    output logic        fx
  );
    logic [16:0] s;
    logic [15:0] nf;
    logic        w;
    w  = wide && (op <= 5'd4);
    f  = 8'h0;
    fx = 1'b0;
    if (w) begin
      lat = 3;
      case (op)
        5'd0: begin
          s = {1'b0, a} + {1'b0, b};
          r = s[15:0];
          f[0] = s[16];
          f[2] = (a[15] == b[15]) && (r[15] != a[15]);
          fx = ({1'b0, a[7:0]} + {1'b0, b[7:0]}) > 9'd255;
        end
        5'd1: begin
          r = a - b;
          f[0] = a < b;
          f[1] = 1'b1;
          f[2] = (a[15] != b[15]) && (r[15] != a[15]);
          fx = a[7:0] < b[7:0];
        end
        5'd2: r = a & b;
        5'd3: r = a | b;
        default: r = a ^ b;
      endcase
      if (fx) lat = 4;
    end else begin
      lat = 2;
      nf = alu_f(op, a[7:0], b[7:0]);
      r = {8'h00, nf[7:0]};
      f[2:0] = nf[10:8];
    end
`ifdef ALU_SEQ_SZ_FLAGS_EN
    f[7] = w ? r[15] : r[7];
    f[6] = (r == 16'h0);
`endif
  endfunction

  function automatic logic [7:0] sz(
    input logic s,
    input logic z
  );
`ifdef ALU_SEQ_SZ_FLAGS_EN
    return {s, z, 6'b0};
`else
    return {1'b0, 1'b0, 6'b0} & {s, z, 6'b0};
`endif
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] want
  );
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h",
               name, got, want);
    end
  endtask

  // compare process: every response cycle against the model
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      vecs++;
      if (!exp_active ||
          rsp_result !== exp_res ||
          rsp_flags !== exp_flags ||
          req_ready !== 1'b0) begin
        errs++;
        $display("FAIL rsp: got %h/%h rdy=%b want %h/%h act=%b",
                 rsp_result, rsp_flags, req_ready,
                 exp_res, exp_flags, exp_active);
      end
    end
  end

  task automatic run_op(
    input logic [4:0]  op,
    input logic        wide,
    input logic [15:0] a,
    input logic [15:0] b,
    input int          hold
  );
    logic [15:0] er;
    logic [7:0]  ef;
    int          el;
    logic        efx;
    int          lat;
    logic        fx;
    logic [4:0]  fixop;
    model(op, wide, a, b, er, ef, el, efx);
    fixop = (op == 5'd0) ? 5'd12 :
            (op == 5'd1) ? 5'd13 : 5'h1F;
    exp_res    = er;
    exp_flags  = ef;
    exp_active = 1'b1;
    req_op     = op;
    req_wide   = wide;
    req_a      = a;
    req_b      = b;
    req_valid  = 1'b1;
    rsp_ready  = (hold == 0);
    chk("accept_ready", {31'b0, req_ready}, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    fx  = 1'b0;
    while (!rsp_valid && lat < 10) begin
      if (wide && alu_opcode == fixop) fx = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, el);
    chk("fix_pass", {31'b0, fx}, {31'b0, efx});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, rsp_valid}, 1);
      chk("hold_ready", {31'b0, req_ready}, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rel_valid", {31'b0, rsp_valid}, 0);
    chk("rel_ready", {31'b0, req_ready}, 1);
    exp_active = 1'b0;
  endtask

  task automatic pin(
    input logic [4:0]  op,
    input logic        wide,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [15:0] wr,
    input logic [7:0]  wf,
    input int          wl
  );
    logic [15:0] r;
    logic [7:0]  f;
    int          l;
    logic        fx;
    model(op, wide, a, b, r, f, l, fx);
    chk("pin_res", {16'h0, r}, {16'h0, wr});
    chk("pin_flags", {24'h0, f}, {24'h0, wf});
    chk("pin_lat", l, wl);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_wide  = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    pin(5'd0, 1'b0, 16'h007F, 16'h0001,
        16'h0080, 8'h04 | sz(1, 0), 2);
    pin(5'd0, 1'b1, 16'h1234, 16'h0101,
        16'h1335, 8'h00 | sz(0, 0), 3);
    pin(5'd0, 1'b1, 16'hFFFF, 16'h0001,
        16'h0000, 8'h01 | sz(0, 1), 4);
    pin(5'd1, 1'b1, 16'h0100, 16'h0001,
        16'h00FF, 8'h02 | sz(0, 0), 4);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, rsp_valid}, 0);
    chk("rst_result", {16'h0, rsp_result}, 0);
    chk("rst_flags", {24'h0, rsp_flags}, 0);
    chk("rst_ready", {31'b0, req_ready}, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", {31'b0, req_ready}, 1);
    chk("idle_opcode", {27'b0, alu_opcode}, 0);
    chk("idle_a", {24'b0, alu_a}, 0);
    @(posedge clk); #1;

    run_op(5'd0, 1'b0, 16'h007F, 16'h0001, 0);
    run_op(5'd0, 1'b1, 16'h1234, 16'h0101, 0);
    run_op(5'd0, 1'b1, 16'hFFFF, 16'h0001, 0);
    run_op(5'd1, 1'b1, 16'h0100, 16'h0001, 0);
    run_op(5'd1, 1'b0, 16'h0005, 16'h0007, 0);
    run_op(5'd2, 1'b0, 16'h003C, 16'h000F, 0);
    run_op(5'd4, 1'b1, 16'hF0F0, 16'h0FF0, 0);
    run_op(5'd12, 1'b1, 16'h12FF, 16'h0000, 0);
    run_op(5'd13, 1'b0, 16'h0000, 16'h0000, 0);
    run_op(5'd0, 1'b1, 16'h7FFF, 16'h0001, 0);
    run_op(5'd1, 1'b1, 16'h8000, 16'h0001, 0);
    run_op(5'd3, 1'b1, 16'h1200, 16'h0034, 0);
    run_op(5'd0, 1'b1, 16'h00F0, 16'h0020, 5);

    // abort a wide op during its HI pass
    exp_active = 1'b0;
    req_op    = 5'd0;
    req_wide  = 1'b1;
    req_a     = 16'hFFFF;
    req_b     = 16'h0001;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("hi_drive_a", {24'b0, alu_a}, 32'hFF);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_valid", {31'b0, rsp_valid}, 0);
    chk("abort_ready", {31'b0, req_ready}, 0);
    reset = 1'b0;
    #1;
    chk("abort_rdy_back", {31'b0, req_ready}, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_rsp", {31'b0, rsp_valid}, 0);
    run_op(5'd0, 1'b1, 16'h1234, 16'h0101, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
